// File: rtl/deserializer_pkg.sv
// -----------------------------------------------------------------------------
// deserializer_pkg
// Framing constants and state type for the word-wide board/move link. The
// serializer imports the same package so both ends agree on word width, words
// per frame and word order (slot 0 = first word on the link).
// -----------------------------------------------------------------------------
package deserializer_pkg;

    localparam int LINK_WORD_W    = 32;
    localparam int LINK_NUM_WORDS = 756;
    localparam int LINK_FRAME_W   = LINK_WORD_W * LINK_NUM_WORDS;
    localparam int LINK_CNT_W     = $clog2(LINK_NUM_WORDS + 1);

    typedef enum logic {
        ST_FILL = 1'b0,   // accepting words into the frame
        ST_FULL = 1'b1    // complete frame held, further words are overflow
    } deser_state_e;

    // Completed-frame counter is 4 bits and wraps 15 -> 0.
    function automatic logic [3:0] frame_cnt_inc(input logic [3:0] cnt);
        return cnt + 4'd1;
    endfunction

endpackage

// File: rtl/deser_slot_decoder.sv
// -----------------------------------------------------------------------------
// deser_slot_decoder
// Turns a slot index plus write enable into a one-hot per-slot write vector
// for the frame register.
//   i_slot_idx : slot to write (0..NUM_WORDS-1; indices >= NUM_WORDS select none)
//   i_wr_en    : write this cycle
//   o_slot_wr  : one-hot slot write strobes (all zero when i_wr_en = 0)
// -----------------------------------------------------------------------------
module deser_slot_decoder
    import deserializer_pkg::*;
#(
    parameter int NUM_WORDS = LINK_NUM_WORDS,
    parameter int CNT_W     = $clog2(NUM_WORDS + 1)
) (
    input  logic [CNT_W-1:0]     i_slot_idx,
    input  logic                 i_wr_en,
    output logic [NUM_WORDS-1:0] o_slot_wr
);

    always_comb begin
        o_slot_wr = '0;
        for (int k = 0; k < NUM_WORDS; k++) begin
            o_slot_wr[k] = i_wr_en && (i_slot_idx == CNT_W'(k));
        end
    end

endmodule

// File: rtl/deserializer.sv
// -----------------------------------------------------------------------------
// deserializer
// Packs a stream of WORD_W-bit words, first word into the lowest slot, into a
// NUM_WORDS-word frame register for the chess engine. Flags a complete frame
// with o_done and counts completed frames modulo 16.
//   i_clk              : clock, all logic on rising edge
//   i_reset            : synchronous active-high reset, overrides everything
//   i_data_in          : incoming word, sampled when i_w_en = 1
//   i_w_en             : word-valid strobe
//   i_clear            : arm a new frame (count, done, overflow to zero)
//   o_data_out         : assembled frame register
//   o_word_count       : words stored in the current frame
//   o_move_counter_out : completed-frame counter, wraps 15 -> 0
//   o_done             : high while a complete frame is held
//   o_overflow         : sticky, a word arrived while the frame was full
// -----------------------------------------------------------------------------
module deserializer
    import deserializer_pkg::*;
#(
    parameter int WORD_W    = LINK_WORD_W,
    parameter int NUM_WORDS = LINK_NUM_WORDS,
    parameter int CNT_W     = $clog2(NUM_WORDS + 1)
) (
    input  logic                        i_clk,
    input  logic                        i_reset,
    input  logic [WORD_W-1:0]           i_data_in,
    input  logic                        i_w_en,
    input  logic                        i_clear,
    output logic [WORD_W*NUM_WORDS-1:0] o_data_out,
    output logic [CNT_W-1:0]            o_word_count,
    output logic [3:0]                  o_move_counter_out,
    output logic                        o_done,
    output logic                        o_overflow
);

    deser_state_e               r_state;
    logic [WORD_W*NUM_WORDS-1:0] r_data_out;
    logic [CNT_W-1:0]           r_word_count;
    logic [3:0]                 r_move_counter;
    logic                       r_done;
    logic                       r_overflow;

    logic                       w_accept;
    logic [CNT_W-1:0]           w_slot_idx;
    logic                       w_last;
    logic [NUM_WORDS-1:0]       w_slot_wr;

    // A clear in the same cycle as a word re-arms the frame first, so the word
    // lands in slot 0 even if the previous frame was full. This is what lets
    // frames run back to back without a bubble.
    assign w_accept   = i_w_en && (i_clear || (r_state == ST_FILL));
    assign w_slot_idx = i_clear ? '0 : r_word_count;
    assign w_last     = (w_slot_idx == CNT_W'(NUM_WORDS - 1));

    deser_slot_decoder #(
        .NUM_WORDS (NUM_WORDS),
        .CNT_W     (CNT_W)
    ) u_slot_decoder (
        .i_slot_idx (w_slot_idx),
        .i_wr_en    (w_accept),
        .o_slot_wr  (w_slot_wr)
    );

    // Frame register: only the addressed slot changes; clear leaves old
    // contents in place until they are overwritten.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_data_out <= '0;
        end else begin
            for (int k = 0; k < NUM_WORDS; k++) begin
                if (w_slot_wr[k]) begin
                    r_data_out[k*WORD_W +: WORD_W] <= i_data_in;
                end
            end
        end
    end

    // Control FSM. Later assignments override earlier ones, so an accepted
    // word after a clear still advances the count and may complete the frame.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state        <= ST_FILL;
            r_word_count   <= '0;
            r_move_counter <= 4'd0;
            r_done         <= 1'b0;
            r_overflow     <= 1'b0;
        end else begin
            if (i_clear) begin
                r_state      <= ST_FILL;
                r_word_count <= '0;
                r_done       <= 1'b0;
                r_overflow   <= 1'b0;
            end
            if (w_accept) begin
                r_word_count <= w_slot_idx + CNT_W'(1);
                if (w_last) begin
                    r_state        <= ST_FULL;
                    r_done         <= 1'b1;
                    r_move_counter <= frame_cnt_inc(r_move_counter);
                end
            end else if (i_w_en) begin
                // Not accepted and no clear: frame is full, word is dropped.
                r_overflow <= 1'b1;
            end
        end
    end

    assign o_data_out         = r_data_out;
    assign o_word_count       = r_word_count;
    assign o_move_counter_out = r_move_counter;
    assign o_done             = r_done;
    assign o_overflow         = r_overflow;

endmodule

// File: tb/tb_deserializer.sv
module tb_deserializer;
    import deserializer_pkg::*;

    localparam int W  = 32;
    localparam int NB = 756;
    localparam int NS = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // big instance (default framing)
    logic          b_rst = 0, b_clr = 0, b_wen = 0;
    logic [W-1:0]  b_din = '0;
    logic [W*NB-1:0] b_dout;
    logic [9:0]    b_cnt;
    logic [3:0]    b_mc;
    logic          b_done, b_ovf;

    // small instance (NUM_WORDS = 4) for wrap / dense corner cases
    logic          s_rst = 0, s_clr = 0, s_wen = 0;
    logic [W-1:0]  s_din = '0;
    logic [W*NS-1:0] s_dout;
    logic [2:0]    s_cnt;
    logic [3:0]    s_mc;
    logic          s_done, s_ovf;

    deserializer #(.WORD_W(W), .NUM_WORDS(NB)) u_big (
        .i_clk(clk), .i_reset(b_rst), .i_data_in(b_din), .i_w_en(b_wen), .i_clear(b_clr),
        .o_data_out(b_dout), .o_word_count(b_cnt), .o_move_counter_out(b_mc),
        .o_done(b_done), .o_overflow(b_ovf)
    );

    deserializer #(.WORD_W(W), .NUM_WORDS(NS)) u_small (
        .i_clk(clk), .i_reset(s_rst), .i_data_in(s_din), .i_w_en(s_wen), .i_clear(s_clr),
        .o_data_out(s_dout), .o_word_count(s_cnt), .o_move_counter_out(s_mc),
        .o_done(s_done), .o_overflow(s_ovf)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: an array of stored words plus counters, indexed by instance.
    logic [31:0] m_slot [2][NB];
    int          m_cnt  [2];
    int          m_mc   [2];
    bit          m_done [2];
    bit          m_ovf  [2];
    int          m_n    [2];

    typedef struct {
        bit          rst;
        bit          clr;
        bit          wen;
        logic [31:0] din;
        int          cnt;
        bit          done;
        bit          ovf;
        int          mc;
    } vec_t;
    vec_t tbl[$];

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [31:0] dut_slot(input int id, input int k);
        if (id == 0) return b_dout[k*W +: W];
        return s_dout[(k % NS)*W +: W];
    endfunction

    function automatic int dut_cnt(input int id);
        return (id == 0) ? int'(b_cnt) : int'(s_cnt);
    endfunction
    function automatic int dut_mc(input int id);
        return (id == 0) ? int'(b_mc) : int'(s_mc);
    endfunction
    function automatic int dut_done(input int id);
        return (id == 0) ? int'(b_done) : int'(s_done);
    endfunction
    function automatic int dut_ovf(input int id);
        return (id == 0) ? int'(b_ovf) : int'(s_ovf);
    endfunction

    // Behavioural rules: a frame is "full" exactly when done is set.
    task automatic model_step(input int id, input bit rst, input bit clr,
                              input bit wen, input logic [31:0] din);
        if (rst) begin
            for (int k = 0; k < m_n[id]; k++) m_slot[id][k] = '0;
            m_cnt[id] = 0; m_done[id] = 0; m_ovf[id] = 0; m_mc[id] = 0;
            return;
        end
        if (clr) begin
            m_cnt[id] = 0; m_done[id] = 0; m_ovf[id] = 0;
        end
        if (wen) begin
            if (m_done[id]) m_ovf[id] = 1;
            else begin
                m_slot[id][m_cnt[id]] = din;
                m_cnt[id]++;
                if (m_cnt[id] == m_n[id]) begin
                    m_done[id] = 1;
                    m_mc[id] = (m_mc[id] + 1) % 16;
                end
            end
        end
    endtask

    task automatic check_flags(input int id);
        string p;
        p = (id == 0) ? "big" : "small";
        check({p, "_word_count"}, dut_cnt(id),  m_cnt[id]);
        check({p, "_done"},       dut_done(id), int'(m_done[id]));
        check({p, "_overflow"},   dut_ovf(id),  int'(m_ovf[id]));
        check({p, "_move_cnt"},   dut_mc(id),   m_mc[id]);
    endtask

    task automatic check_data(input int id, input string name);
        int bad_slot;
        bad_slot = -1;
        for (int k = 0; k < m_n[id]; k++) begin
            if (bad_slot < 0 && dut_slot(id, k) !== m_slot[id][k]) bad_slot = k;
        end
        checks++;
        if (bad_slot >= 0) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s: slot %0d got %08h expected %08h", name, bad_slot,
                         dut_slot(id, bad_slot), m_slot[id][bad_slot]);
        end
    endtask

    // Apply one cycle of inputs to one instance; the other instance idles.
    task automatic step(input int id, input bit rst, input bit clr,
                        input bit wen, input logic [31:0] din);
        if (id == 0) begin
            b_rst = rst; b_clr = clr; b_wen = wen; b_din = din;
        end else begin
            s_rst = rst; s_clr = clr; s_wen = wen; s_din = din;
        end
        @(posedge clk);
        model_step(id, rst, clr, wen, din);
        #1;
        b_rst = 0; b_clr = 0; b_wen = 0; b_din = '0;
        s_rst = 0; s_clr = 0; s_wen = 0; s_din = '0;
        check_flags(id);
    endtask

    function automatic int count_bad_ramp();
        int bad;
        bad = 0;
        for (int k = 0; k < NB; k++)
            if (b_dout[k*W +: W] !== 32'(k)) bad++;
        return bad;
    endfunction

    initial begin
        m_n[0] = NB;
        m_n[1] = NS;

        // ---------------- small-instance vector table ----------------
        tbl.push_back('{1, 0, 1, 32'hFFFF_FFFF, 0, 0, 0, 0});
        tbl.push_back('{1, 0, 1, 32'hFFFF_FFFF, 0, 0, 0, 0});
        for (int f = 1; f <= 17; f++) begin
            tbl.push_back('{0, 1, 0, 32'h0, 0, 0, 0, (f - 1) % 16});
            for (int i = 0; i < NS; i++)
                tbl.push_back('{0, 0, 1, 32'(f * 16 + i), i + 1, (i == NS - 1), 0,
                                (i == NS - 1) ? f % 16 : (f - 1) % 16});
        end
        tbl.push_back('{0, 0, 1, 32'h77, 4, 1, 1, 1});           // overflow
        tbl.push_back('{0, 0, 1, 32'h78, 4, 1, 1, 1});           // stays sticky
        tbl.push_back('{0, 1, 1, 32'h99, 1, 0, 0, 1});           // clear + write
        tbl.push_back('{1, 1, 1, 32'h55, 0, 0, 0, 0});           // reset wins

        // ---------------- big instance: reset with w_en high ----------------
        step(0, 1, 0, 1, 32'hFFFF_FFFF);
        step(0, 1, 0, 1, 32'hFFFF_FFFF);
        check("rst_data_zero", int'(b_dout == '0), 1);
        check("rst_count", b_cnt, 0);
        check_data(0, "rst_data");

        // ---------------- small instance: table ----------------
        foreach (tbl[i]) begin
            step(1, tbl[i].rst, tbl[i].clr, tbl[i].wen, tbl[i].din);
            check("tbl_count",    s_cnt,  tbl[i].cnt);
            check("tbl_done",     s_done, tbl[i].done);
            check("tbl_overflow", s_ovf,  tbl[i].ovf);
            check("tbl_move_cnt", s_mc,   tbl[i].mc);
        end

        // ---------------- big: full frame, word k = k ----------------
        for (int k = 0; k < NB; k++) begin
            step(0, 0, 0, 1, 32'(k));
            if (k == NB - 2) check("ff_done_early", b_done, 0);
        end
        check("ff_count", b_cnt, 756);
        check("ff_done", b_done, 1);
        check("ff_move_cnt", b_mc, 1);
        check("ff_slots_bad", count_bad_ramp(), 0);
        check_data(0, "ff_data");

        // ---------------- big: gapped fill then overflow ----------------
        step(0, 0, 1, 0, 32'h0);
        check("gap_clear_done", b_done, 0);
        for (int k = 0; k < NB; k++) begin
            step(0, 0, 0, 1, 32'(k));
            step(0, 0, 0, 0, 32'hFFFF_FFFF);
        end
        check("gap_count", b_cnt, 756);
        check("gap_done", b_done, 1);
        check("gap_move_cnt", b_mc, 2);
        check("gap_slots_bad", count_bad_ramp(), 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 32'hDEAD_BEEF);
        check("ovf_flag", b_ovf, 1);
        check("ovf_count", b_cnt, 756);
        check("ovf_slots_bad", count_bad_ramp(), 0);
        check_data(0, "ovf_data");

        // ---------------- big: clear together with write ----------------
        step(0, 0, 1, 1, 32'hA5A5_A5A5);
        check("cw_done", b_done, 0);
        check("cw_overflow", b_ovf, 0);
        check("cw_count", b_cnt, 1);
        check("cw_slot0", b_dout[31:0], 32'hA5A5_A5A5);
        check("cw_slot1", b_dout[63:32], 1);

        // ---------------- big: reset mid-frame then refill ----------------
        for (int k = 1; k < 300; k++) step(0, 0, 0, 1, 32'(k + 5000));
        check("mid_count", b_cnt, 300);
        step(0, 1, 0, 0, 32'h0);
        check("mid_rst_count", b_cnt, 0);
        check("mid_rst_data_zero", int'(b_dout == '0), 1);
        check("mid_rst_move_cnt", b_mc, 0);
        for (int k = 0; k < NB; k++) step(0, 0, 0, 1, ~32'(k));
        check("refill_done", b_done, 1);
        check("refill_move_cnt", b_mc, 1);
        check_data(0, "refill_data");

        // ---------------- randomized: small instance ----------------
        for (int i = 0; i < 1500; i++) begin
            step(1, $urandom_range(0, 49) == 0, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 9) < 7, $urandom);
            check_data(1, "rnd_small_data");
        end

        // ---------------- randomized: big instance ----------------
        step(0, 0, 1, 0, 32'h0);
        for (int i = 0; i < 2500; i++) begin
            bit was_done;
            was_done = b_done;
            step(0, $urandom_range(0, 1999) == 0, $urandom_range(0, 1999) == 0,
                 $urandom_range(0, 9) < 9, $urandom);
            if (b_done && !was_done) check_data(0, "rnd_big_frame");
        end
        check_data(0, "rnd_big_end");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
